notifier_collector: RTL

- Downstream consumer of timing-check notifier registers: one notifier line per checked instance, each toggling once per setup/hold violation.
- Synchronizes each line and detects toggles.
- Suppresses detections during a post-reset blanking window, the RTL analogue of a warnings-disabled interval.
- Keeps saturating per-channel counts and sticky flags, and emits timestamped violation events over a valid/ready stream for the bench scoreboard.

---
 rtl/notifier_pkg.sv | 24 ++
 rtl/notifier_collector_if.sv | 15 +
 rtl/notif_evt_fifo.sv | 63 ++++++
 rtl/notifier_collector.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/notifier_pkg.sv
// Shared constants, width helper and event record for the notifier collector.
// Default parameter values live here so the top and FIFO agree on them.
// The event record pairs a channel index with its detection timestamp.
package notifier_pkg;

  localparam int NUM_CH_DEF       = 2;
  localparam int CNT_W_DEF        = 8;
  localparam int TS_W_DEF         = 16;
  localparam int BLANK_CYCLES_DEF = 21;
  localparam int FIFO_DEPTH_DEF   = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NOTIF_CH_W = ch_w(NUM_CH_DEF);

  typedef struct packed {
    logic [NOTIF_CH_W-1:0] ch;
    logic [TS_W_DEF-1:0]   ts;
  } notif_evt_t;

endpackage

// File: rtl/notifier_collector_if.sv
// Violation event stream: channel + timestamp with valid/ready handshake.
// master drives the event, slave (consumer) drives ready.
// Signal names keep the producer-side _o/_i direction suffixes.
interface notifier_collector_if #(
  parameter int CH_W = 1,
  parameter int TS_W = 16
);
  logic            evt_valid_o;
  logic            evt_ready_i;
  logic [CH_W-1:0] evt_ch_o;
  logic [TS_W-1:0] evt_ts_o;

  modport master (output evt_valid_o, output evt_ch_o, output evt_ts_o, input evt_ready_i);
  modport slave  (input evt_valid_o, input evt_ch_o, input evt_ts_o, output evt_ready_i);
endinterface

// File: rtl/notif_evt_fifo.sv
// First-word-fall-through event FIFO with synchronous flush.
// Latency: a push is visible on o_dat/~o_empty after the next clock edge.
// Backpressure: o_full blocks pushes; flush drops contents and wins over push/pop.
module notif_evt_fifo
  import notifier_pkg::*;
#(
  parameter type T     = notif_evt_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_push,
  input  T     i_dat,
  output logic o_full,
  input  logic i_pop,
  output T     o_dat,
  output logic o_empty
);
  // DEPTH is a power of two so pointers wrap naturally.
  localparam int AW = ch_w(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push & ~o_full & ~i_flush;
  assign w_pop   = i_pop & ~o_empty & ~i_flush;
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dat   = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/notifier_collector.sv
// Syncs notifier lines, detects toggles, counts violations and queues timestamped events.
// Latency: notifier edge -> count/sticky/pending at 3rd clk edge, evt_valid_o after the 4th.
// Backpressure: full FIFO holds pending bits; a second detection on a pending channel sets overflow_o.
module notifier_collector
  import notifier_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TS_W         = TS_W_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       notifier_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  notifier_collector_if.master    evt_if,
  output logic [NUM_CH*CNT_W-1:0] viol_cnt_o,
  output logic [NUM_CH-1:0]       sticky_o,
  output logic                    overflow_o,
  output logic                    blanking_o
);
  localparam int CH_W  = ch_w(NUM_CH);
  localparam int BLK_W = ch_w(BLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Event record sized from this instance's parameters.
  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] ts;
  } evt_t;

  logic [NUM_CH-1:0] r_s1;
  logic [NUM_CH-1:0] r_s2;
  logic [NUM_CH-1:0] r_prev;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_sticky;
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [TS_W-1:0]   r_pend_ts [NUM_CH];
  logic [TS_W-1:0]   r_ts;
  logic [BLK_W-1:0]  r_blank;
  logic              r_ovf;

  logic [NUM_CH-1:0] w_det;
  logic [NUM_CH-1:0] w_qdet;
  logic [NUM_CH-1:0] w_gnt;
  logic              w_qual;
  logic              w_gnt_vld;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  evt_t              w_push_dat;
  evt_t              w_head;

  // prev tracks s2 unconditionally, so a toggle masked now never shows up later.
  assign w_det      = r_s2 ^ r_prev;
  assign w_qual     = enable_i & ~clear_i & ~blanking_o;
  assign w_qdet     = w_det & {NUM_CH{w_qual}};
  assign blanking_o = (r_blank != '0);
  assign sticky_o   = r_sticky;
  assign overflow_o = r_ovf;

  // Two-flop synchronizer plus previous-value register per channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= notifier_i;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  // Free-running timestamp and post-reset blanking countdown; clear leaves both alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts    <= '0;
      r_blank <= BLK_W'(BLANK_CYCLES);
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (r_blank != '0) r_blank <= r_blank - BLK_W'(1);
    end
  end

  // Fixed-priority grant: lowest pending channel moves to the FIFO when there is room.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt      = '0;
    w_push_dat = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (r_pend[c]) begin
        w_gnt_vld     = 1'b1;
        w_gnt         = '0;
        w_gnt[c]      = 1'b1;
        w_push_dat.ch = CH_W'(c);
        w_push_dat.ts = r_pend_ts[c];
      end
    end
    w_push = w_gnt_vld & ~w_full & ~clear_i;
    if (!w_push) w_gnt = '0;
  end

  // Counters, sticky flags, pending slots and overflow; clear beats same-cycle detections.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_sticky <= '0;
      r_ovf    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]     <= '0;
        r_pend_ts[c] <= '0;
      end
    end else if (clear_i) begin
      r_pend   <= '0;
      r_sticky <= '0;
      r_ovf    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_qdet[c]) begin
          r_sticky[c] <= 1'b1;
          if (r_cnt[c] != CNT_MAX) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
        end
        // A detection on an occupied slot is counted but not queued (overflow below).
        if (w_qdet[c] && !r_pend[c]) begin
          r_pend[c]    <= 1'b1;
          r_pend_ts[c] <= r_ts;
        end else if (w_gnt[c]) begin
          r_pend[c] <= 1'b0;
        end
      end
      if (|(w_qdet & r_pend)) r_ovf <= 1'b1;
    end
  end

  // Pack per-channel counters, channel 0 in the LSBs.
  always_comb begin
    viol_cnt_o = '0;
    for (int c = 0; c < NUM_CH; c++) viol_cnt_o[c*CNT_W +: CNT_W] = r_cnt[c];
  end

  notif_evt_fifo #(
    .T     (evt_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (clear_i),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .o_full  (w_full),
    .i_pop   (evt_if.evt_ready_i),
    .o_dat   (w_head),
    .o_empty (w_empty)
  );

  assign evt_if.evt_valid_o = ~w_empty;
  assign evt_if.evt_ch_o    = w_head.ch;
  assign evt_if.evt_ts_o    = w_head.ts;

endmodule
